// File: rtl/led_pkg.sv
// Shared encodings and constants for the LED pattern sequencer.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BINARY = 2'd3
  } mode_t;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // Terminal prescaler value for a step period of ms milliseconds at freq Hz.
  function automatic int count_step(input int freq, input int ms);
    return (freq / 1000) * ms - 1;
  endfunction

endpackage

// File: rtl/led_step_timer.sv
// Step prescaler: counts 0..COUNT_STEP while enabled and flags the last count.
module led_step_timer
  import led_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int STEP_MS         = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int COUNT_STEP = count_step(CLOCK_FREQUENCY, STEP_MS);
  localparam int CNT_W      = (COUNT_STEP > 0) ? $clog2(COUNT_STEP + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COUNT_STEP);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      if (count == CNT_MAX) count <= '0;
      else                  count <= count + CNT_W'(1);
    end
  end

  assign tick = en && (count == CNT_MAX);

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED bank sequencer: step timer, mode-change handshake FSM and per-mode pattern state.
module led_pattern_sequencer
  import led_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int STEP_MS         = 100,
  parameter int NUM_LEDS        = 6,
  parameter int RESET_MODE      = 1,
  parameter int LED_ACTIVE_LOW  = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Mode_Req,
  input  logic [1:0]          Mode_Sel,
  input  logic                Pause,
  output logic                Mode_Ack,
  output logic [1:0]          Mode,
  output logic                Step_Tick,
  output logic [NUM_LEDS-1:0] Led
);

  localparam int POS_W = $clog2(NUM_LEDS);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);
  localparam mode_t INIT_MODE = mode_t'(2'(RESET_MODE));

  state_t              state, state_nx;
  mode_t               mode, mode_nx, pend_mode, pend_nx;
  logic                rearm, rearm_nx, ack_nx;
  logic                phase, phase_nx;
  logic [POS_W-1:0]    pos, pos_nx;
  logic                dir_down, dir_nx;
  logic [NUM_LEDS-1:0] cnt, cnt_nx;
  logic                tick;

  // Logical pattern for a mode and pattern state, mapped to pin polarity.
  function automatic logic [NUM_LEDS-1:0] led_drive(input mode_t m, input logic ph,
                                                    input logic [POS_W-1:0] p,
                                                    input logic [NUM_LEDS-1:0] c);
    logic [NUM_LEDS-1:0] l;
    l = '0;
    case (m)
      MODE_BLINK:  l = {NUM_LEDS{ph}};
      MODE_CHASE:  l = NUM_LEDS'(1) << p;
      MODE_BINARY: l = c;
      default:     l = '0;
    endcase
    return (LED_ACTIVE_LOW != 0) ? ~l : l;
  endfunction

  led_step_timer #(
    .CLOCK_FREQUENCY(CLOCK_FREQUENCY),
    .STEP_MS        (STEP_MS)
  ) u_timer (
    .clk (Clock),
    .rst (Reset),
    .en  (!Pause),
    .tick(tick)
  );

  assign Step_Tick = tick;
  assign Mode      = mode;

  always_comb begin
    state_nx = state;
    mode_nx  = mode;
    pend_nx  = pend_mode;
    rearm_nx = rearm;
    ack_nx   = 1'b0;
    phase_nx = phase;
    pos_nx   = pos;
    dir_nx   = dir_down;
    cnt_nx   = cnt;

    if (!Mode_Req) rearm_nx = 1'b1;

    // All pattern generators advance together; only the active mode is displayed.
    if (tick) begin
      phase_nx = ~phase;
      cnt_nx   = cnt + NUM_LEDS'(1);
      if (!dir_down) begin
        if (pos == POS_LAST) begin
          dir_nx = 1'b1;
          pos_nx = pos - POS_W'(1);
        end else begin
          pos_nx = pos + POS_W'(1);
        end
      end else begin
        if (pos == '0) begin
          dir_nx = 1'b0;
          pos_nx = POS_W'(1);
        end else begin
          pos_nx = pos - POS_W'(1);
        end
      end
    end

    case (state)
      ST_RUN: begin
        if (Mode_Req && rearm) begin
          pend_nx  = mode_t'(Mode_Sel);
          state_nx = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (tick) begin
          mode_nx  = pend_mode;
          ack_nx   = 1'b1;
          rearm_nx = 1'b0;
          phase_nx = 1'b0;
          pos_nx   = '0;
          dir_nx   = 1'b0;
          cnt_nx   = '0;
          state_nx = ST_RUN;
        end
      end
      default: state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= ST_RUN;
      mode      <= INIT_MODE;
      pend_mode <= INIT_MODE;
      rearm     <= 1'b1;
      Mode_Ack  <= 1'b0;
      phase     <= 1'b0;
      pos       <= '0;
      dir_down  <= 1'b0;
      cnt       <= '0;
      Led       <= led_drive(INIT_MODE, 1'b0, '0, '0);
    end else begin
      state     <= state_nx;
      mode      <= mode_nx;
      pend_mode <= pend_nx;
      rearm     <= rearm_nx;
      Mode_Ack  <= ack_nx;
      phase     <= phase_nx;
      pos       <= pos_nx;
      dir_down  <= dir_nx;
      cnt       <= cnt_nx;
      Led       <= led_drive(mode_nx, phase_nx, pos_nx, cnt_nx);
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer: tick every 10 cycles, active-high and active-low instances.
module tb_led_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst, req, pause;
  logic [1:0] sel, mode;
  logic       tick, ack;
  logic [5:0] led;

  logic       rst_b, req_b;
  logic [1:0] sel_b, mode_b;
  logic       tick_b, ack_b;
  logic [5:0] led_b;

  int tests = 0;
  int fails = 0;
  int k = 0;
  int ack_cnt = 0;
  int ack_b_cnt = 0;
  int base;

  typedef struct packed {
    logic       req;
    logic [1:0] sel;
    logic       pause;
    logic       tick;
    logic       ack;
    logic [1:0] mode;
    logic [5:0] led;
  } vec_t;

  vec_t       tbl [9];
  logic [5:0] chase_exp [10];

  always #5 clk = ~clk;

  led_pattern_sequencer #(
    .CLOCK_FREQUENCY(10000), .STEP_MS(1), .NUM_LEDS(6),
    .RESET_MODE(1), .LED_ACTIVE_LOW(0)
  ) dut (
    .Clock(clk), .Reset(rst), .Mode_Req(req), .Mode_Sel(sel), .Pause(pause),
    .Mode_Ack(ack), .Mode(mode), .Step_Tick(tick), .Led(led)
  );

  led_pattern_sequencer #(
    .CLOCK_FREQUENCY(10000), .STEP_MS(1), .NUM_LEDS(6),
    .RESET_MODE(3), .LED_ACTIVE_LOW(1)
  ) dut_b (
    .Clock(clk), .Reset(rst_b), .Mode_Req(req_b), .Mode_Sel(sel_b), .Pause(1'b0),
    .Mode_Ack(ack_b), .Mode(mode_b), .Step_Tick(tick_b), .Led(led_b)
  );

  always @(negedge clk) begin
    if (ack)   ack_cnt++;
    if (ack_b) ack_b_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at k=%0d: got 'h%0h, expected 'h%0h", name, k, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic goto(input int target);
    while (k < target) next();
  endtask

  initial begin
    tbl[0] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd1, 6'b000000};
    tbl[1] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd1, 6'b000000};
    tbl[2] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd1, 6'b000000};
    tbl[3] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd1, 6'b000000};
    tbl[4] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd1, 6'b000000};
    tbl[5] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd1, 6'b000000};
    tbl[6] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 2'd1, 6'b000000};
    tbl[7] = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 2'd2, 6'b000001};
    tbl[8] = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 2'd2, 6'b000001};
    chase_exp[0] = 6'b000010; chase_exp[1] = 6'b000100; chase_exp[2] = 6'b001000;
    chase_exp[3] = 6'b010000; chase_exp[4] = 6'b100000; chase_exp[5] = 6'b010000;
    chase_exp[6] = 6'b001000; chase_exp[7] = 6'b000100; chase_exp[8] = 6'b000010;
    chase_exp[9] = 6'b000001;

    rst = 1'b1; req = 1'b0; sel = 2'd0; pause = 1'b0;
    rst_b = 1'b1; req_b = 1'b0; sel_b = 2'd0;
    repeat (3) next();
    rst = 1'b0;
    k = 0;

    // Reset state and BLINK timing
    check("rst_mode", mode, 2'd1);
    check("rst_ack", ack, 1'b0);
    check("rst_led", led, 6'b000000);
    check("rst_tick", tick, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      next();
      check("blink_tick", tick, (k % 10 == 9) ? 1 : 0);
      check("blink_led", led, ((k / 10) % 2 == 1) ? 6'b111111 : 6'b000000);
    end

    // Request CHASE at prescaler 3, cycle-by-cycle table
    goto(43);
    for (int i = 0; i < 9; i++) begin
      req = tbl[i].req; sel = tbl[i].sel; pause = tbl[i].pause;
      #1;
      check("req2_tick", tick, tbl[i].tick);
      check("req2_ack", ack, tbl[i].ack);
      check("req2_mode", mode, tbl[i].mode);
      check("req2_led", led, tbl[i].led);
      next();
    end
    for (int s = 1; s <= 10; s++) begin
      goto(50 + 10 * s);
      check("chase_led", led, chase_exp[s-1]);
    end

    // Request BINARY in a Step_Tick cycle
    goto(159);
    req = 1'b1; sel = 2'd3;
    check("t3_tick", tick, 1'b1);
    goto(160);
    check("t3_mode_hold", mode, 2'd2);
    check("t3_ack_hold", ack, 1'b0);
    check("t3_led_hold", led, 6'b000010);
    goto(170);
    check("t3_ack", ack, 1'b1);
    check("t3_mode", mode, 2'd3);
    check("t3_led0", led, 6'b000000);
    req = 1'b0;
    for (int j = 1; j <= 64; j++) begin
      goto(170 + 10 * j);
      check("binary_led", led, j % 64);
    end

    // Held request, Mode_Sel changed while pending
    goto(810);
    base = ack_cnt;
    req = 1'b1; sel = 2'd0;
    goto(812);
    sel = 2'd3;
    goto(820);
    check("t4_ack", ack, 1'b1);
    check("t4_mode", mode, 2'd0);
    check("t4_led", led, 6'b000000);
    goto(860);
    req = 1'b0;
    check("t4_ack_count", ack_cnt - base, 1);

    // Pause with a request pending
    goto(863);
    base = ack_cnt;
    req = 1'b1; sel = 2'd1;
    goto(864);
    pause = 1'b1;
    for (int i = 0; i < 25; i++) begin
      #1;
      check("t5_pause_tick", tick, 1'b0);
      check("t5_pause_mode", mode, 2'd0);
      check("t5_pause_led", led, 6'b000000);
      next();
    end
    check("t5_pause_ackcnt", ack_cnt - base, 0);
    pause = 1'b0;
    while (k <= 894) begin
      #1;
      check("t5_resume_tick", tick, (k == 894) ? 1 : 0);
      next();
    end
    check("t5_ack", ack, 1'b1);
    check("t5_mode", mode, 2'd1);
    check("t5_led", led, 6'b000000);
    req = 1'b0;
    goto(896);
    check("t5_ack_count", ack_cnt - base, 1);
    goto(905);
    check("t5_blink_led", led, 6'b111111);

    // Active-low instance, BINARY reset mode
    check("b_rst_mode", mode_b, 2'd3);
    check("b_rst_led", led_b, 6'b111111);
    check("b_rst_ack", ack_b, 1'b0);
    rst_b = 1'b0;
    k = 0;
    goto(49);
    check("b_led4", led_b, 6'b111011);
    goto(50);
    check("b_led5", led_b, 6'b111010);
    goto(53);
    ack_b_cnt = 0;
    req_b = 1'b1; sel_b = 2'd2;
    goto(54);
    rst_b = 1'b1; req_b = 1'b0;
    goto(55);
    check("b_pend_rst_mode", mode_b, 2'd3);
    check("b_pend_rst_led", led_b, 6'b111111);
    goto(56);
    rst_b = 1'b0;
    goto(100);
    check("b_no_ack", ack_b_cnt, 0);
    check("b_mode_kept", mode_b, 2'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
